// File: rtl/gpio_control_wrapper.sv
// Wishbone-programmable pad mux: each pad picks one of NUM_DESIGNS user designs via a 4-bit select field.
// Optional select-register lock enabled with `define GPIO_CTRL_LOCK_EN (register at offset 0x14).
module gpio_control_wrapper #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_DESIGNS = 13,
    parameter int          NUM_PINS    = 38
) (
    input  logic                                  wb_clk_i,
    input  logic                                  wb_rst_i,
    input  logic                                  wbs_stb_i,
    input  logic                                  wbs_cyc_i,
    input  logic                                  wbs_we_i,
    input  logic [3:0]                            wbs_sel_i,
    input  logic [31:0]                           wbs_adr_i,
    input  logic [31:0]                           wbs_dat_i,
    output logic                                  wbs_ack_o,
    output logic [31:0]                           wbs_dat_o,
    input  logic [NUM_DESIGNS-1:0][NUM_PINS-1:0]  designs_gpio_out,
    input  logic [NUM_DESIGNS-1:0][NUM_PINS-1:0]  designs_gpio_oeb,
    output logic [NUM_PINS-1:0]                   gpio_out,
    output logic [NUM_PINS-1:0]                   gpio_oeb
);

    logic [3:0]  sel_q [NUM_PINS];
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;
    logic        locked;
    logic        decoded;
    logic [2:0]  offset;
    logic        start;
    logic        wr_en;
    logic        rd_en;
    logic        adr_unused;

    assign decoded    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign offset     = wbs_adr_i[4:2];
    assign start      = decoded & ~ack_q;
    assign wr_en      = start & wbs_we_i;
    assign rd_en      = start & ~wbs_we_i;
    assign adr_unused = ^wbs_adr_i[1:0];

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

`ifdef GPIO_CTRL_LOCK_EN
    logic lock_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lock_q <= 1'b0;
        end else if (wr_en && offset == 3'd5 && wbs_sel_i[0] && wbs_dat_i[0]) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    // Pad p lives in register p/8, nibble p%8; unused nibbles and offsets read as zero.
    always_comb begin
        rdata = 32'h0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (offset == 3'(p / 8)) begin
                rdata[4*(p%8) +: 4] = sel_q[p];
            end
        end
`ifdef GPIO_CTRL_LOCK_EN
        if (offset == 3'd5) begin
            rdata = {31'h0, lock_q};
        end
`endif
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
            for (int p = 0; p < NUM_PINS; p++) begin
                sel_q[p] <= 4'h0;
            end
        end else begin
            ack_q <= start;
            dat_q <= rd_en ? rdata : 32'h0;
            if (wr_en && !locked) begin
                for (int p = 0; p < NUM_PINS; p++) begin
                    if (offset == 3'(p / 8) && wbs_sel_i[(p%8)/2]) begin
                        sel_q[p] <= wbs_dat_i[4*(p%8) +: 4];
                    end
                end
            end
        end
    end

    // Out-of-range selects tri-state the pad.
    always_comb begin
        gpio_out = '0;
        gpio_oeb = '1;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (int'(sel_q[p]) < NUM_DESIGNS) begin
                gpio_out[p] = designs_gpio_out[sel_q[p]][p];
                gpio_oeb[p] = designs_gpio_oeb[sel_q[p]][p];
            end
        end
    end

endmodule

// File: tb/tb_gpio_control_wrapper.sv
// Randomized bench for gpio_control_wrapper against a register-image reference model.
// Lock checks are compiled in when GPIO_CTRL_LOCK_EN is defined.
module tb_gpio_control_wrapper;

    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef GPIO_CTRL_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              stb, cyc, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat_i;
    logic              ack;
    logic [31:0]       dat_o;
    logic [12:0][37:0] dout, doeb;
    logic [37:0]       gout, goeb;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] regm [8];
    logic        lock_m;
    logic [31:0] last_rd;

    gpio_control_wrapper #(.BASE_ADDR(BASE), .NUM_DESIGNS(13), .NUM_PINS(38)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .designs_gpio_out(dout), .designs_gpio_oeb(doeb),
        .gpio_out(gout), .gpio_oeb(goeb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vmask(input int o);
        if (o < 4) return 32'hFFFF_FFFF;
        if (o == 4) return 32'h00FF_FFFF;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_reg(input int o);
        if (o < 5) return regm[o];
        if (o == 5 && LOCK) return {31'h0, lock_m};
        return 32'h0;
    endfunction

    function automatic int pad_sel(input int p);
        return int'((regm[p/8] >> (4*(p%8))) & 32'hF);
    endfunction

    function automatic logic [37:0] exp_out();
        logic [37:0] e = '0;
        for (int p = 0; p < 38; p++) if (pad_sel(p) < 13) e[p] = dout[pad_sel(p)][p];
        return e;
    endfunction

    function automatic logic [37:0] exp_oeb();
        logic [37:0] e = '1;
        for (int p = 0; p < 38; p++) if (pad_sel(p) < 13) e[p] = doeb[pad_sel(p)][p];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) regm[i] = 32'h0;
        lock_m = 1'b0;
    endtask

    task automatic model_write(input int o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        if (LOCK && o == 5 && s[0] && d[0]) lock_m = 1'b1;
        if (o < 5 && !lock_m) regm[o] = ((regm[o] & ~m) | (d & m)) & vmask(o);
    endtask

    task automatic check_pads(input string tag);
        chk({tag, "_out"}, gout, exp_out());
        chk({tag, "_oeb"}, goeb, exp_oeb());
    endtask

    task automatic wb_acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic hit;
        hit = (a[31:5] == BASE[31:5]);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        @(posedge clk); #1;
        chk("ack", ack, hit);
        if (hit && !w) chk("rdata", dat_o, exp_reg(int'(a[4:2])));
        else           chk("dat_idle", dat_o, 32'h0);
        last_rd = dat_o;
        if (hit && w) model_write(int'(a[4:2]), d, s);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_width", ack, 1'b0);
        check_pads("pads");
    endtask

    task automatic rand_inputs();
        for (int d = 0; d < 13; d++) begin
            dout[d] = 38'({$urandom, $urandom});
            doeb[d] = 38'({$urandom, $urandom});
        end
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
        model_reset();
        rand_inputs();
        #1;
        chk("rst_ack", ack, 1'b0);
        chk("rst_dat", dat_o, 32'h0);
        check_pads("rst_pads");
        chk("rst_oeb_d0", goeb, doeb[0]);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        dout = '0; doeb = '0; doeb[0][12] = 1'b1;
        #1 chk("oeb12", goeb, 38'h1 << 12);
        dout[2][8] = 1'b1;
        wb_acc(1'b1, 32'h04, 32'h2, 4'hF);
        chk("out8", gout[8], 1'b1);

        wb_acc(1'b1, 32'h00, 32'd12, 4'hF);
        wb_acc(1'b1, 32'h04, 32'd8, 4'hF);
        wb_acc(1'b1, 32'h08, 32'd7, 4'hF);
        wb_acc(1'b0, 32'h00, 32'h0, 4'hF); chk("rd00", last_rd, 32'h0000_000C);
        wb_acc(1'b0, 32'h04, 32'h0, 4'hF); chk("rd04", last_rd, 32'h0000_0008);
        wb_acc(1'b0, 32'h08, 32'h0, 4'hF); chk("rd08", last_rd, 32'h0000_0007);

        dout = '1; doeb = '0;
        wb_acc(1'b1, 32'h00, 32'h0000_000F, 4'hF);
        chk("tri_out0", gout[0], 1'b0);
        chk("tri_oeb0", goeb[0], 1'b1);

        wb_acc(1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF);
        wb_acc(1'b1, 32'h00, 32'h0, 4'hF);
        wb_acc(1'b1, 32'h00, 32'hFFFF_FFFF, 4'b0010);
        wb_acc(1'b0, 32'h00, 32'h0, 4'hF); chk("rd_bytesel", last_rd, 32'h0000_FF00);

        wb_acc(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
        wb_acc(1'b0, 32'h13, 32'h0, 4'hF); chk("rd10", last_rd, 32'h00FF_FFFF);

        // Held strobe on a read: ack toggles every cycle.
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("held_ack", ack, (i % 2) == 0);
            chk("held_dat", dat_o, ((i % 2) == 0) ? 32'h00FF_FFFF : 32'h0);
        end
        stb = 1'b0; cyc = 1'b0;

        // Reset lands between strobe and the acking edge.
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 32'h10; dat_i = 32'h1234_5678; sel = 4'hF;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack", ack, 1'b0);
        chk("midrst_dat", dat_o, 32'h0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        model_reset();
        @(negedge clk) rst = 1'b0;
        wb_acc(1'b0, 32'h10, 32'h0, 4'hF); chk("rd10_after_rst", last_rd, 32'h0);
        wb_acc(1'b0, 32'h00, 32'h0, 4'hF); chk("rd00_after_rst", last_rd, 32'h0);

        for (int it = 0; it < 300; it++) begin
            logic [31:0] a, d;
            rand_inputs();
            a = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
            if ($urandom_range(0, 9) == 0) a[31:5] = 27'($urandom_range(1, 32'h7FF_FFFF));
            d = $urandom;
            if (a[4:2] == 3'd5) d[0] = 1'b0;
            wb_acc(1'($urandom), a, d, 4'($urandom));
        end

        if (LOCK) begin
            wb_acc(1'b1, 32'h00, 32'h0000_0003, 4'hF);
            wb_acc(1'b1, 32'h14, 32'h1, 4'hF);
            wb_acc(1'b1, 32'h00, 32'h5, 4'hF);
            wb_acc(1'b0, 32'h00, 32'h0, 4'hF); chk("lock_rd00", last_rd, 32'h0000_0003);
            wb_acc(1'b0, 32'h14, 32'h0, 4'hF); chk("lock_rd14", last_rd, 32'h1);
        end else begin
            wb_acc(1'b1, 32'h14, 32'h1, 4'hF);
            wb_acc(1'b0, 32'h14, 32'h0, 4'hF); chk("nolock_rd14", last_rd, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_control_wrapper.md
GPIO_CONTROL_WRAPPER -- requirements
Module: gpio_control_wrapper

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, Wishbone base address of the 32-byte register window; SHALL be 32-byte aligned.
REQ-002 Parameter: NUM_DESIGNS, 13, number of user designs competing for the pads.
REQ-003 Parameter: NUM_PINS, 38, number of GPIO pads.
REQ-004 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 wbs_stb_i  input  1  Wishbone strobe.
REQ-007 wbs_cyc_i  input  1  Wishbone cycle.
REQ-008 wbs_we_i  input  1  Wishbone write enable (1 = write).
REQ-009 wbs_sel_i  input  4  Wishbone byte selects; bit n covers data bits [8n+7:8n].
REQ-010 wbs_adr_i  input  32  Wishbone byte address.
REQ-011 wbs_dat_i  input  32  Wishbone write data.
REQ-012 wbs_ack_o  output  1  Wishbone acknowledge.
REQ-013 wbs_dat_o  output  32  Wishbone read data.
REQ-014 designs_gpio_out  input  [12:0][37:0]  per-design pad output values.
REQ-015 designs_gpio_oeb  input  [12:0][37:0]  per-design pad output-enable-bar (1 = pad is input).
REQ-016 gpio_out  output  38  muxed pad output values.
REQ-017 gpio_oeb  output  38  muxed pad output-enable-bar.

Function
REQ-018 Each pad p SHALL have a 4-bit select field SEL[p]; SEL[p] is held in register p/8 at byte offset 4*(p/8), bits [4*(p%8)+3 : 4*(p%8)].
- Registers: 0x00 pads 0-7, 0x04 pads 8-15, 0x08 pads 16-23, 0x0C pads 24-31, 0x10 pads 32-37 (bits 31:24 read 0, writes ignored).
REQ-019 Access decode: stb & cyc & (wbs_adr_i[31:5] == BASE_ADDR[31:5]); offset = wbs_adr_i[4:2]; wbs_adr_i[1:0] ignored.
REQ-020 wbs_ack_o SHALL assert for exactly one cycle, one cycle after a decoded access is first sampled (ack_next = decoded & ~ack); a held strobe produces ack every other cycle.
REQ-021 Writes SHALL update only bytes with wbs_sel_i set, on the same edge that raises ack.
REQ-022 Reads SHALL return the register contents on wbs_dat_o, registered with ack; wbs_dat_o SHALL be 0 whenever wbs_ack_o is 0.
REQ-023 Decoded accesses to offsets 0x14-0x1C SHALL be acked, reads return 0, writes are ignored (except REQ-030).
REQ-024 Non-decoded addresses SHALL never be acked.
REQ-025 gpio_out[p] = designs_gpio_out[SEL[p]][p], gpio_oeb[p] = designs_gpio_oeb[SEL[p]][p]; combinational, zero-cycle latency from inputs and registers.
REQ-026 SEL[p] >= 13 (13-15) SHALL yield gpio_out[p] = 0, gpio_oeb[p] = 1 (pad tri-stated).

Reset
REQ-027 While wb_rst_i = 1: all select fields = 0 (design 0 owns every pad), wbs_ack_o = 0, wbs_dat_o = 0, lock cleared.
REQ-028 Reset asserted mid-transaction SHALL abort it immediately; no register update, no ack; the master must retry after reset.

Configuration
REQ-029 Macro GPIO_CTRL_LOCK_EN selects the lock feature.
REQ-030 Defined: offset 0x14 is a lock register (bit 0, write-1-to-set, readable, cleared only by reset); once set, writes to 0x00-0x10 are acked but ignored.
REQ-031 Not defined: no lock register; 0x14 behaves per REQ-023.

Verification
REQ-032 Write 12 to 0x00, 8 to 0x04, 7 to 0x08, then read each back -> reads return 0x0000000C, 0x00000008, 0x00000007; each ack one cycle wide.
REQ-033 Set designs_gpio_oeb[0][12] = 1, all others 0, after reset -> gpio_oeb[12] = 1, all other gpio_oeb bits 0; after writing 0x00000002 to 0x04 with designs_gpio_out[2][8] = 1 -> gpio_out[8] = 1.
REQ-034 Write 0x0000000F to 0x00 -> gpio_out[0] = 0, gpio_oeb[0] = 1 regardless of design inputs.
REQ-035 Write 0xFFFFFFFF to 0x00 with wbs_sel_i = 4'b0010, then read -> 0x0000FF00.
REQ-036 Write 0xFFFFFFFF to 0x10 -> read returns 0x00FFFFFF; assert wb_rst_i mid-write -> no ack, register reads 0 afterwards.
REQ-037 With GPIO_CTRL_LOCK_EN: write 1 to 0x14, then 0x5 to 0x00 -> 0x00 reads unchanged, 0x14 reads 1.
